// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter and read-hazard gate for the 16x32 register file.
// Two single-entry hold registers feed one registered write port with round-robin fairness.
module regfile_wr_arbiter #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid_i,
    output logic          a_ready_o,
    input  logic [AW-1:0] a_rd_i,
    input  logic [DW-1:0] a_data_i,
    input  logic          b_valid_i,
    output logic          b_ready_o,
    input  logic [AW-1:0] b_rd_i,
    input  logic [DW-1:0] b_data_i,
    input  logic          rd_req_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          rd_stall_o,
    output logic          rd_allow_o,
    output logic [AW-1:0] Rs1_o,
    output logic [AW-1:0] Rs2_o,
    output logic          wr_allow_o,
    output logic [AW-1:0] Rd_o,
    output logic [DW-1:0] DI_o
);

    typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;

    logic          haValid_q, haValid_d, hbValid_q, hbValid_d;
    logic [AW-1:0] haRd_q, haRd_d, hbRd_q, hbRd_d;
    logic [DW-1:0] haData_q, haData_d, hbData_q, hbData_d;
    logic          bOlder_q, bOlder_d;
    rr_e           rr_q, rr_d;
    logic          wrAllow_q, wrAllow_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] di_q, di_d;

    logic sameRd, grantA, grantB, acceptA, acceptB, contended;

    // bOlder_q only matters while both holds are valid; it breaks same-rd ties so writes stay in order
    assign sameRd    = (haRd_q == hbRd_q);
    assign contended = haValid_q && hbValid_q && !sameRd;
    assign grantA    = haValid_q && (!hbValid_q || (sameRd ? !bOlder_q : (rr_q == RR_A)));
    assign grantB    = hbValid_q && (!haValid_q || (sameRd ?  bOlder_q : (rr_q == RR_B)));

    assign a_ready_o = !haValid_q || grantA;
    assign b_ready_o = !hbValid_q || grantB;
    assign acceptA   = a_valid_i && a_ready_o;
    assign acceptB   = b_valid_i && b_ready_o;

    always_comb begin
        haValid_d = haValid_q;
        haRd_d    = haRd_q;
        haData_d  = haData_q;
        hbValid_d = hbValid_q;
        hbRd_d    = hbRd_q;
        hbData_d  = hbData_q;
        bOlder_d  = bOlder_q;
        rr_d      = rr_q;
        wrAllow_d = grantA || grantB;
        rd_d      = rd_q;
        di_d      = di_q;

        if (grantA) begin
            haValid_d = 1'b0;
            rd_d      = haRd_q;
            di_d      = haData_q;
        end else if (grantB) begin
            rd_d      = hbRd_q;
            di_d      = hbData_q;
        end
        if (grantB) hbValid_d = 1'b0;

        if (acceptA) begin
            haValid_d = 1'b1;
            haRd_d    = a_rd_i;
            haData_d  = a_data_i;
        end
        if (acceptB) begin
            hbValid_d = 1'b1;
            hbRd_d    = b_rd_i;
            hbData_d  = b_data_i;
        end

        // A fresh entry is always younger than a surviving one; simultaneous arrivals favour A
        if (acceptA && acceptB)  bOlder_d = 1'b0;
        else if (acceptA)        bOlder_d = 1'b1;
        else if (acceptB)        bOlder_d = 1'b0;

        if (contended) rr_d = grantA ? RR_B : RR_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haValid_q <= 1'b0;
            haRd_q    <= '0;
            haData_q  <= '0;
            hbValid_q <= 1'b0;
            hbRd_q    <= '0;
            hbData_q  <= '0;
            bOlder_q  <= 1'b0;
            rr_q      <= RR_A;
            wrAllow_q <= 1'b0;
            rd_q      <= '0;
            di_q      <= '0;
        end else begin
            haValid_q <= haValid_d;
            haRd_q    <= haRd_d;
            haData_q  <= haData_d;
            hbValid_q <= hbValid_d;
            hbRd_q    <= hbRd_d;
            hbData_q  <= hbData_d;
            bOlder_q  <= bOlder_d;
            rr_q      <= rr_d;
            wrAllow_q <= wrAllow_d;
            rd_q      <= rd_d;
            di_q      <= di_d;
        end
    end

    function automatic logic hit(input logic [AW-1:0] r);
        return (haValid_q && haRd_q == r) || (hbValid_q && hbRd_q == r) || (wrAllow_q && rd_q == r);
    endfunction

    assign rd_stall_o = rd_req_i && (hit(rs1_i) || hit(rs2_i));
    assign rd_allow_o = rd_req_i && !rd_stall_o;
    assign Rs1_o      = rs1_i;
    assign Rs2_o      = rs2_i;
    assign wr_allow_o = wrAllow_q;
    assign Rd_o       = rd_q;
    assign DI_o       = di_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized plus directed bench for regfile_wr_arbiter; a sequence-number model predicts every write,
// and a negedge monitor checks each write the DUT issues against the predicted queue.
module tb_regfile_wr_arbiter;
   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          aValid = 1'b0, aReady, bValid = 1'b0, bReady;
   logic [AW-1:0] aRd = '0, bRd = '0, rs1 = '0, rs2 = '0;
   logic [DW-1:0] aData = '0, bData = '0;
   logic          rdReq = 1'b0, rdStall, rdAllow, wrAllow;
   logic [AW-1:0] rs1Out, rs2Out, rdOut;
   logic [DW-1:0] diOut;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {logic [AW-1:0] rd; logic [DW-1:0] data;} wr_t;
   typedef struct {int cyc; logic [AW-1:0] rd; logic [DW-1:0] data;} exp_t;

   wr_t  stimA[$], stimB[$];
   exp_t expQ[$];

   // Reference model: each hold keeps a global arrival number, so "older" is simply the smaller number
   bit            mAv, mBv, mRrB, mOutV;
   wr_t           mA, mB;
   int            mAseq, mBseq, seqCtr;
   logic [AW-1:0] mOutRd;
   bit            aHeld, bHeld;

   regfile_wr_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid_i(aValid), .a_ready_o(aReady), .a_rd_i(aRd), .a_data_i(aData),
      .b_valid_i(bValid), .b_ready_o(bReady), .b_rd_i(bRd), .b_data_i(bData),
      .rd_req_i(rdReq), .rs1_i(rs1), .rs2_i(rs2),
      .rd_stall_o(rdStall), .rd_allow_o(rdAllow), .Rs1_o(rs1Out), .Rs2_o(rs2Out),
      .wr_allow_o(wrAllow), .Rd_o(rdOut), .DI_o(diOut)
   );

   always #5 clk = ~clk;

   // One comparison: bumps the vector count and reports a mismatch
   function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic bit modelHit(input logic [AW-1:0] r);
      return (mAv && mA.rd == r) || (mBv && mB.rd == r) || (mOutV && mOutRd == r);
   endfunction

   function automatic void modelReset();
      mAv = 0; mBv = 0; mRrB = 0; mOutV = 0; mOutRd = '0;
      aHeld = 0; bHeld = 0;
      stimA.delete(); stimB.delete(); expQ.delete();
   endfunction

   // Drives one cycle from the negedge, checks combinational outputs, then advances the model over the edge
   task automatic applyStimulus(input bit gateA, input bit gateB, input bit req,
                                input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      bit gA, gB, rdyA, rdyB, accA, accB, stall;
      aValid = aHeld || (gateA && stimA.size() > 0);
      bValid = bHeld || (gateB && stimB.size() > 0);
      if (aValid) begin aRd = stimA[0].rd; aData = stimA[0].data; end
      if (bValid) begin bRd = stimB[0].rd; bData = stimB[0].data; end
      rdReq = req; rs1 = r1; rs2 = r2;
      #1;
      gA = 0; gB = 0;
      if (mAv && mBv) begin
         if (mA.rd == mB.rd) begin gA = (mAseq < mBseq); gB = !gA; end
         else begin gA = !mRrB; gB = mRrB; end
      end else begin
         gA = mAv; gB = mBv;
      end
      rdyA = !mAv || gA;
      rdyB = !mBv || gB;
      stall = req && (modelHit(r1) || modelHit(r2));
      checkOutput("a_ready", 64'(aReady), 64'(rdyA));
      checkOutput("b_ready", 64'(bReady), 64'(rdyB));
      checkOutput("rd_stall", 64'(rdStall), 64'(stall));
      checkOutput("rd_allow", 64'(rdAllow), 64'(req && !stall));
      checkOutput("Rs1", 64'(rs1Out), 64'(r1));
      checkOutput("Rs2", 64'(rs2Out), 64'(r2));
      accA = aValid && rdyA;
      accB = bValid && rdyB;
      if (gA)      begin expQ.push_back('{cyc + 1, mA.rd, mA.data}); mOutV = 1; mOutRd = mA.rd; end
      else if (gB) begin expQ.push_back('{cyc + 1, mB.rd, mB.data}); mOutV = 1; mOutRd = mB.rd; end
      else mOutV = 0;
      if (mAv && mBv && mA.rd != mB.rd) mRrB = gA;
      if (gA) mAv = 0;
      if (gB) mBv = 0;
      if (accA) begin mAv = 1; mA = stimA.pop_front(); mAseq = seqCtr++; end
      if (accB) begin mBv = 1; mB = stimB.pop_front(); mBseq = seqCtr++; end
      aHeld = aValid && !accA;
      bHeld = bValid && !accB;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, '0, '0);
   endtask

   // Monitor: every write the DUT presents must match the next predicted write, in the predicted cycle
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && wrAllow) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_write: got Rd=%0h DI=%0h expected no write (cycle %0d)", rdOut, diOut, cyc);
         end else begin
            e = expQ.pop_front();
            checkOutput("write_cycle", 64'(cyc), 64'(e.cyc));
            checkOutput("write_Rd", 64'(rdOut), 64'(e.rd));
            checkOutput("write_DI", 64'(diOut), 64'(e.data));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      wr_t w;
      int  budget;
      modelReset();
      seqCtr = 0;

      // Reset with A already requesting
      aValid = 1; aRd = 4'd9; aData = 32'hDEAD; rdReq = 1; rs1 = '0; rs2 = '0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_wr_allow", 64'(wrAllow), 64'(0));
      checkOutput("reset_Rd", 64'(rdOut), 64'(0));
      checkOutput("reset_DI", 64'(diOut), 64'(0));
      checkOutput("reset_a_ready", 64'(aReady), 64'(1));
      checkOutput("reset_b_ready", 64'(bReady), 64'(1));
      checkOutput("reset_rd_allow", 64'(rdAllow), 64'(1));
      @(negedge clk);
      rst_n = 1;
      aValid = 0;
      stimA.push_back('{4'd0, 32'h45});
      idle(3);

      // Lone stream on A
      stimA.push_back('{4'd1, 32'h33});
      stimA.push_back('{4'd4, 32'h777});
      stimA.push_back('{4'd7, 32'h69});
      idle(5);

      // Continuous contention, different rd
      for (int i = 0; i < 4; i++) begin
         stimA.push_back('{4'd2, 32'hA0 + 32'(i)});
         stimB.push_back('{4'd3, 32'hB0 + 32'(i)});
      end
      idle(10);

      // Same-rd ordering: staggered, then simultaneous
      stimA.push_back('{4'd5, 32'h11});
      applyStimulus(1, 0, 0, '0, '0);
      stimB.push_back('{4'd5, 32'h22});
      idle(4);
      stimA.push_back('{4'd5, 32'h33});
      stimB.push_back('{4'd5, 32'h44});
      idle(4);

      // Hazard gate on rd=4, then a clean read
      stimA.push_back('{4'd4, 32'h1234});
      stimB.push_back('{4'd6, 32'h5678});
      for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 4'd4, 4'd7);
      applyStimulus(1, 1, 1, 4'd3, 4'd7);

      // Randomized traffic with narrow rd range to provoke same-rd collisions and hazards
      for (int i = 0; i < 400; i++) begin
         if (stimA.size() < 2 && $urandom_range(0, 1) == 1) begin
            w.rd = AW'($urandom_range(0, 3)); w.data = $urandom; stimA.push_back(w);
         end
         if (stimB.size() < 2 && $urandom_range(0, 1) == 1) begin
            w.rd = AW'($urandom_range(0, 3)); w.data = $urandom; stimB.push_back(w);
         end
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 5)), AW'($urandom_range(0, 5)));
      end
      idle(4);

      // Reset mid-flight: fill both holds and the output stage, then drop rst_n between edges
      for (int i = 0; i < 6; i++) begin
         stimA.push_back('{4'd6, 32'hC0 + 32'(i)});
         stimB.push_back('{4'd8, 32'hD0 + 32'(i)});
      end
      budget = 0;
      do begin
         applyStimulus(1, 1, 0, '0, '0);
         budget++;
      end while (!(mAv && mBv && mOutV) && budget < 20);
      checkOutput("midflight_setup", 64'(mAv && mBv && mOutV), 64'(1));
      checkOutput("midflight_wr_allow_before", 64'(wrAllow), 64'(1));
      #2;
      rst_n = 0;
      #1;
      checkOutput("midflight_wr_allow", 64'(wrAllow), 64'(0));
      checkOutput("midflight_a_ready", 64'(aReady), 64'(1));
      checkOutput("midflight_b_ready", 64'(bReady), 64'(1));
      checkOutput("midflight_Rd", 64'(rdOut), 64'(0));
      modelReset();
      aValid = 0; bValid = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      idle(6);

      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
